fact_accel: RTL and testbench

//  Memory-mapped factorial accelerator: the responder side of the mips_top data-memory bus.
//  The CPU writes n and a go bit with sw, polls a status word with lw, then reads n!.

---
 rtl/fact_accel_if.sv | 13 +
 rtl/fact_accel.sv | 121 ++++++++++++
 tb/tb_fact_accel.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fact_accel_if.sv
// Data-memory bus slice between the CPU address decoder and the factorial accelerator.
// Writes take effect at the rising edge; rd is combinational from addr.
interface fact_accel_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  we;
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd;

  modport master (output we, addr, wd, input rd);
  modport slave  (input we, addr, wd, output rd);
endinterface

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial: one multiply per clock, done after max(n,1) edges past the go write.
// No backpressure: bus writes are always accepted and reads are combinational without side effects.
module fact_accel #(
  parameter int DATA_WIDTH = 32,
  parameter int N_WIDTH    = 4,
  parameter int N_MAX      = 12
) (
  input  logic         clk,
  input  logic         rst,
  fact_accel_if.slave  bus
);

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [N_WIDTH-1:0] N_MAX_C = N_WIDTH'(N_MAX);
  localparam logic [N_WIDTH-1:0] ONE_N   = N_WIDTH'(1);

  logic [1:0]            state_q,  state_d;
  logic [N_WIDTH-1:0]    n_q,      n_d;
  logic                  go_q,     go_d;
  logic                  done_q,   done_d;
  logic                  err_q,    err_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] acc_q,    acc_d;
  logic [N_WIDTH-1:0]    cnt_q,    cnt_d;

  logic                  go_wr;
  logic                  n_wr;
  logic [DATA_WIDTH-1:0] cnt_ext;
  logic [DATA_WIDTH-1:0] rd_dat;

  assign go_wr   = bus.we && (bus.addr == ADDR_GO);
  assign n_wr    = bus.we && (bus.addr == ADDR_N);
  assign cnt_ext = {{(DATA_WIDTH-N_WIDTH){1'b0}}, cnt_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    go_d     = go_q;
    done_d   = done_q;
    err_d    = err_q;
    result_d = result_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    if (n_wr)  n_d  = bus.wd[N_WIDTH-1:0];
    if (go_wr) go_d = bus.wd[0];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // The operand is latched here, so later N writes cannot disturb a running job.
        if (go_wr && bus.wd[0]) begin
          state_d = ST_CALC;
          cnt_d   = n_q;
          acc_d   = DATA_WIDTH'(1);
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_CALC: begin
        if (cnt_q > N_MAX_C) begin
          state_d  = ST_DONE;
          err_d    = 1'b1;
          done_d   = 1'b1;
          result_d = '0;
        end else if (cnt_q <= ONE_N) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          result_d = acc_q;
        end else begin
          acc_d = acc_q * cnt_ext;
          cnt_d = cnt_q - ONE_N;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_dat = '0;
    case (bus.addr)
      ADDR_N:      rd_dat[N_WIDTH-1:0] = n_q;
      ADDR_GO:     rd_dat[0]           = go_q;
      ADDR_STATUS: rd_dat[1:0]         = {err_q, done_q};
      ADDR_RESULT: rd_dat              = result_q;
      default:     rd_dat              = '0;
    endcase
  end

  assign bus.rd = rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      go_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      go_q     <= go_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fact_accel.sv
// Directed bench for fact_accel: drives the bus interface and checks reads against hand-computed values.
module tb_fact_accel;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  fact_accel_if #(.DATA_WIDTH(32)) bus ();

  fact_accel #(.DATA_WIDTH(32), .N_WIDTH(4), .N_MAX(12)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [1:0] A_N = 2'd0, A_GO = 2'd1, A_ST = 2'd2, A_RES = 2'd3;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    @(posedge clk);
    #1;
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    bus.addr = a;
    #1;
    v = bus.rd;
  endtask

  task automatic test_reset();
    logic [31:0] got;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), got);
      tests_run++;
      if (got !== 32'd0) begin
        $display("FAIL reset_reg%0d got=%h exp=%h", i, got, 32'd0);
        tests_failed++;
      end
    end
  endtask

  task automatic test_fact5();
    logic [31:0] got;
    bus_write(A_N, 32'd5);
    rd_reg(A_N, got);
    tests_run++;
    if (got !== 32'd5) begin $display("FAIL f5_n_readback got=%h exp=%h", got, 32'd5); tests_failed++; end
    bus_write(A_GO, 32'd1);
    rd_reg(A_GO, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL f5_go_readback got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL f5_status_e0 got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(4);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL f5_status_e4 got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(1);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL f5_status_e5 got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd120) begin $display("FAIL f5_result got=%h exp=%h", got, 32'd120); tests_failed++; end
  endtask

  task automatic test_small_n();
    logic [31:0] got;
    for (int n = 0; n < 2; n++) begin
      bus_write(A_N, 32'(n));
      bus_write(A_GO, 32'd1);
      rd_reg(A_ST, got);
      tests_run++;
      if (got !== 32'd0) begin $display("FAIL small%0d_status_e0 got=%h exp=%h", n, got, 32'd0); tests_failed++; end
      step(1);
      rd_reg(A_ST, got);
      tests_run++;
      if (got !== 32'd1) begin $display("FAIL small%0d_status_e1 got=%h exp=%h", n, got, 32'd1); tests_failed++; end
      rd_reg(A_RES, got);
      tests_run++;
      if (got !== 32'd1) begin $display("FAIL small%0d_result got=%h exp=%h", n, got, 32'd1); tests_failed++; end
    end
  endtask

  task automatic test_max_n();
    logic [31:0] got;
    bus_write(A_N, 32'd12);
    bus_write(A_GO, 32'd1);
    step(11);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL max_status_e11 got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(1);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL max_status_e12 got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'h1C8C_FC00) begin $display("FAIL max_result got=%h exp=%h", got, 32'h1C8C_FC00); tests_failed++; end
  endtask

  task automatic test_err_then_recover();
    logic [31:0] got;
    bus_write(A_N, 32'd13);
    bus_write(A_GO, 32'd1);
    step(1);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd3) begin $display("FAIL err_status got=%h exp=%h", got, 32'd3); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL err_result got=%h exp=%h", got, 32'd0); tests_failed++; end
    // Writes to read-only registers must be dropped.
    bus_write(A_ST, 32'hFFFF_FFFF);
    bus_write(A_RES, 32'hDEAD_BEEF);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd3) begin $display("FAIL ro_status got=%h exp=%h", got, 32'd3); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL ro_result got=%h exp=%h", got, 32'd0); tests_failed++; end
    bus_write(A_N, 32'd3);
    bus_write(A_GO, 32'd1);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL rec_status_cleared got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(3);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL rec_status got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd6) begin $display("FAIL rec_result got=%h exp=%h", got, 32'd6); tests_failed++; end
  endtask

  task automatic test_go_zero();
    logic [31:0] got;
    bus_write(A_GO, 32'd0);
    rd_reg(A_GO, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL go0_readback got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(2);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL go0_status got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd6) begin $display("FAIL go0_result got=%h exp=%h", got, 32'd6); tests_failed++; end
  endtask

  task automatic test_write_during_calc();
    logic [31:0] got;
    bus_write(A_N, 32'd6);
    bus_write(A_GO, 32'd1);
    bus_write(A_N, 32'd2);
    bus_write(A_GO, 32'd1);
    rd_reg(A_N, got);
    tests_run++;
    if (got !== 32'd2) begin $display("FAIL mid_n_readback got=%h exp=%h", got, 32'd2); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd6) begin $display("FAIL mid_result_held got=%h exp=%h", got, 32'd6); tests_failed++; end
    step(3);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL mid_status_e5 got=%h exp=%h", got, 32'd0); tests_failed++; end
    step(1);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL mid_status_e6 got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd720) begin $display("FAIL mid_result got=%h exp=%h", got, 32'd720); tests_failed++; end
  endtask

  task automatic test_reset_during_calc();
    logic [31:0] got;
    bus_write(A_N, 32'd10);
    bus_write(A_GO, 32'd1);
    step(3);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), got);
      tests_run++;
      if (got !== 32'd0) begin $display("FAIL abort_reg%0d got=%h exp=%h", i, got, 32'd0); tests_failed++; end
    end
    step(10);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd0) begin $display("FAIL abort_no_done got=%h exp=%h", got, 32'd0); tests_failed++; end
    bus_write(A_N, 32'd4);
    bus_write(A_GO, 32'd1);
    step(4);
    rd_reg(A_ST, got);
    tests_run++;
    if (got !== 32'd1) begin $display("FAIL post_rst_status got=%h exp=%h", got, 32'd1); tests_failed++; end
    rd_reg(A_RES, got);
    tests_run++;
    if (got !== 32'd24) begin $display("FAIL post_rst_result got=%h exp=%h", got, 32'd24); tests_failed++; end
  endtask

  initial begin
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.wd   = '0;
    test_reset();
    test_fact5();
    test_small_n();
    test_max_n();
    test_err_then_recover();
    test_go_zero();
    test_write_during_calc();
    test_reset_during_calc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
